// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - redirect source / redirect output bundle for fetch_redirect_ctrl
`ifndef INST_LEN
`define INST_LEN 32
`endif

interface fetch_redirect_ctrl_if #(
    parameter int EPOCH_W = 3
);
    logic                 stall_i;
    logic [`INST_LEN-1:0] clint_pc_i;
    logic                 clint_pc_valid_i;
    logic [`INST_LEN-1:0] branch_pc_i;
    logic                 branch_pc_valid_i;
    logic [`INST_LEN-1:0] bpu_pc_i;
    logic                 bpu_pc_valid_i;
    logic [`INST_LEN-1:0] ifu_pc_i;
    logic                 ifu_pc_valid_i;
    logic [`INST_LEN-1:0] redir_pc_o;
    logic                 redir_valid_o;
    logic [1:0]           redir_src_o;
    logic                 flush_if_o;
    logic                 flush_id_o;
    logic                 flush_ex_o;
    logic                 pending_o;
    logic [EPOCH_W-1:0]   epoch_o;

    modport master (
        output stall_i, clint_pc_i, clint_pc_valid_i, branch_pc_i, branch_pc_valid_i,
               bpu_pc_i, bpu_pc_valid_i, ifu_pc_i, ifu_pc_valid_i,
        input  redir_pc_o, redir_valid_o, redir_src_o, flush_if_o, flush_id_o,
               flush_ex_o, pending_o, epoch_o
    );

    modport slave (
        input  stall_i, clint_pc_i, clint_pc_valid_i, branch_pc_i, branch_pc_valid_i,
               bpu_pc_i, bpu_pc_valid_i, ifu_pc_i, ifu_pc_valid_i,
        output redir_pc_o, redir_valid_o, redir_src_o, flush_if_o, flush_id_o,
               flush_ex_o, pending_o, epoch_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - PC redirect arbiter with one-entry stall buffer and flush strobes
// Optional epoch counter enabled by defining FETCH_REDIR_EPOCH_EN.
`ifndef INST_LEN
`define INST_LEN 32
`endif

module fetch_redirect_ctrl #(
    parameter int EPOCH_W = 3
) (
    input logic                 clk,
    input logic                 rst,
    fetch_redirect_ctrl_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state, state_nxt;
    logic [`INST_LEN-1:0] buf_pc, buf_pc_nxt;
    logic [1:0]           buf_src, buf_src_nxt;

    logic                 in_valid;
    logic [1:0]           in_code;
    logic [`INST_LEN-1:0] in_pc;
    logic                 win_valid;
    logic [1:0]           win_code;
    logic [`INST_LEN-1:0] win_pc;
    logic                 issue;
    logic                 valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            buf_pc  <= '0;
            buf_src <= '0;
        end else begin
            state   <= state_nxt;
            buf_pc  <= buf_pc_nxt;
            buf_src <= buf_src_nxt;
        end
    end

    always_comb begin
        in_valid = 1'b1;
        in_code  = 2'd0;
        in_pc    = '0;
        if (bus.clint_pc_valid_i) begin
            in_code = 2'd3;
            in_pc   = bus.clint_pc_i;
        end else if (bus.branch_pc_valid_i) begin
            in_code = 2'd2;
            in_pc   = bus.branch_pc_i;
        end else if (bus.bpu_pc_valid_i) begin
            in_code = 2'd1;
            in_pc   = bus.bpu_pc_i;
        end else if (bus.ifu_pc_valid_i) begin
            in_code = 2'd0;
            in_pc   = bus.ifu_pc_i;
        end else begin
            in_valid = 1'b0;
        end

        // The held request is older, so it keeps ties against an equal-priority newcomer.
        win_valid = in_valid;
        win_code  = in_code;
        win_pc    = in_pc;
        if (state == HOLD && (!in_valid || buf_src >= in_code)) begin
            win_valid = 1'b1;
            win_code  = buf_src;
            win_pc    = buf_pc;
        end

        state_nxt   = state;
        buf_pc_nxt  = buf_pc;
        buf_src_nxt = buf_src;
        issue       = 1'b0;
        if (win_valid) begin
            if (bus.stall_i) begin
                state_nxt   = HOLD;
                buf_pc_nxt  = win_pc;
                buf_src_nxt = win_code;
            end else begin
                issue     = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    assign valid             = issue && !rst;
    assign bus.redir_valid_o = valid;
    assign bus.redir_pc_o    = valid ? win_pc : '0;
    assign bus.redir_src_o   = valid ? win_code : 2'd0;
    assign bus.flush_if_o    = valid;
    assign bus.flush_id_o    = valid && (win_code >= 2'd2);
    assign bus.flush_ex_o    = valid && (win_code == 2'd3);
    assign bus.pending_o     = (state == HOLD) && !rst;

`ifdef FETCH_REDIR_EPOCH_EN
    logic [EPOCH_W-1:0] epoch;

    always_ff @(posedge clk) begin
        if (rst) begin
            epoch <= '0;
        end else if (issue) begin
            epoch <= epoch + EPOCH_W'(1);
        end
    end

    assign bus.epoch_o = rst ? '0 : epoch;
`else
    assign bus.epoch_o = '0;
`endif
endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Arbitrates the four PC redirect sources (CLINT trap, EX branch, BPU prediction, IFU correction) into a single qualified redirect for the PC register, and generates per-stage flush strobes. Redirects that arrive while the front end is stalled are captured in a one-entry pending buffer and issued on the first unstalled cycle, so no redirect is lost. Sits between the trap/branch/predict producers and the PC register; its redirect output replaces the raw source valids at the PC register.

## Interface
- EPOCH_W, 3: width of the fetch-epoch counter.
- `INST_LEN` (macro, sysconfig): width of all PC buses.

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  front-end stall; redirect may not issue while high
- clint_pc_i  in  `INST_LEN`  trap target
- clint_pc_valid_i  in  1  trap request (priority 3, highest)
- branch_pc_i  in  `INST_LEN`  branch target from EX
- branch_pc_valid_i  in  1  branch mispredict request (priority 2)
- bpu_pc_i  in  `INST_LEN`  predicted target
- bpu_pc_valid_i  in  1  prediction request (priority 1)
- ifu_pc_i  in  `INST_LEN`  IFU corrected PC
- ifu_pc_valid_i  in  1  IFU correction request (priority 0, lowest)
- redir_pc_o  out  `INST_LEN`  redirect target to PC register
- redir_valid_o  out  1  redirect issued this cycle
- redir_src_o  out  2  priority code of issued redirect (3 trap … 0 ifu)
- flush_if_o  out  1  flush IF stage
- flush_id_o  out  1  flush ID stage
- flush_ex_o  out  1  flush EX stage
- pending_o  out  1  a redirect is held in the buffer
- epoch_o  out  EPOCH_W  fetch epoch, tags fetched instructions

## Operation
- States: IDLE (buffer empty), HOLD (buffer holds pc + 2-bit source code).
- Candidate set each cycle: all asserted inputs plus the buffer entry (if HOLD). Winner = highest priority code; the buffer entry wins ties against an incoming request of equal code (older request is architecturally correct).
- stall_i low and a winner exists: issue winner: redir_valid_o=1, redir_pc_o/redir_src_o = winner; all losers dropped; next state IDLE.
- stall_i high and a winner exists: no issue; winner written into buffer; next state HOLD. Buffer entry is replaced only by a strictly higher code.
- No candidates: redir_valid_o=0; state unchanged (IDLE).
- Flush strobes, asserted only with redir_valid_o: code 3 -> IF, ID, EX; code 2 -> IF, ID; codes 1, 0 -> IF only.
- redir_pc_o, redir_src_o are 0 when redir_valid_o=0.
- pending_o = (state == HOLD).

## Timing
- Issue path is combinational: request with stall_i low at cycle N -> redir_valid_o in cycle N; PC register loads target at edge end of N.
- Request during stall -> captured at end of cycle; issued in first cycle with stall_i low (zero extra latency after stall release).
- Buffer/state/epoch update on rising clk only.
- Epoch increments by 1 at the edge ending each issue cycle; wraps 2^EPOCH_W-1 -> 0.
- Reset (any state, including HOLD): state IDLE, buffer cleared (pending request discarded), epoch_o=0; all outputs 0 during and after reset until a request arrives. Requests asserted in a reset cycle are ignored.

## Configuration
- FETCH_REDIR_EPOCH_EN defined: epoch counter implemented as above.
- Not defined: counter removed, epoch_o tied to 0; all other behaviour identical.

## Test plan
- Single branch, stall_i=0, branch_pc_i=0x8000_0100 -> same cycle redir_valid_o=1, redir_pc_o=0x8000_0100, redir_src_o=2, flush_if_o=flush_id_o=1, flush_ex_o=0; epoch 0->1.
- Simultaneous trap 0x8000_0004 and bpu 0x8000_0200, stall_i=0 -> issue 0x8000_0004, src 3, all three flushes; bpu dropped, no issue next cycle.
- Branch 0x100 during stall (3 cycles), then trap 0x4 while still stalled -> pending_o=1, buffer replaced by trap; on release issues 0x4 src 3 exactly once, pending_o=0.
- bpu 0x200 held in HOLD, then ifu 0x300 and new bpu 0x400 while stalled -> buffer keeps 0x200; issued on release.
- HOLD with branch pending, rst=1 for one cycle -> pending_o=0, epoch_o=0, no issue after release with no new requests.
- 8 back-to-back ifu redirects with EPOCH_W=3 -> epoch_o 0..7 then wraps to 0; with macro undefined epoch_o stays 0.
